// File: rtl/bitwise_op_pipe_if.sv
// Operand/result handshake bundle for bitwise_op_pipe; slave is the block, master drives operands and consumes results.
interface bitwise_op_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_all1;
    logic             out_parity;
    logic [CNT_W-1:0] txn_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_all1, out_parity, txn_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_all1, out_parity, txn_count
    );
endinterface

// File: rtl/bitwise_op_pipe.sv
// Registered WIDTH-bit AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS unit feeding a 2-entry in-order result buffer.
// One cycle into an empty buffer; in_ready comes from occupancy only, so no combinational path from out_ready.
module bitwise_op_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bitwise_op_pipe_if.slave   bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             all1;
        logic             parity;
    } entry_t;

    entry_t           mem_q [2];
    entry_t           push_entry;
    entry_t           head;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res;
    logic             push;
    logic             pop;

    assign bus.in_ready  = (occ_q != 2'd2);
    assign bus.out_valid = (occ_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        case (bus.in_op)
            3'b000:  res = bus.in_a & bus.in_b;
            3'b001:  res = bus.in_a | bus.in_b;
            3'b010:  res = bus.in_a ^ bus.in_b;
            3'b011:  res = ~(bus.in_a & bus.in_b);
            3'b100:  res = ~(bus.in_a | bus.in_b);
            3'b101:  res = ~(bus.in_a ^ bus.in_b);
            3'b110:  res = ~bus.in_a;
            default: res = bus.in_a;
        endcase
        // Flags travel with the result so the consumer never sees them recomputed.
        push_entry.data   = res;
        push_entry.zero   = (res == '0);
        push_entry.all1   = &res;
        push_entry.parity = ^res;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {{WIDTH{1'b0}}, 3'b100};
            mem_q[1] <= {{WIDTH{1'b0}}, 3'b100};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            occ_q <= occ_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.out_data   = head.data;
    assign bus.out_zero   = head.zero;
    assign bus.out_all1   = head.all1;
    assign bus.out_parity = head.parity;
    assign bus.txn_count  = cnt_q;
endmodule

// File: doc/bitwise_op_pipe.md
# bitwise_op_pipe

Parametrised, registered bitwise logic unit that generalises the two-input gate primitives (AND/OR/XOR and their complements) to WIDTH-bit operands with a runtime operation select. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. Each result carries reduction flags, and the block keeps a wrapping count of delivered results. It sits between an operand producer and a consumer that may stall, replacing hard-wired single-bit gates in datapaths.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the delivered-result counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept an operand set this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation select (see Operation)
- out_valid  output  1  result available at buffer head
- out_ready  input  1  consumer takes head result this cycle
- out_data  output  WIDTH  head result
- out_zero  output  1  head result == 0
- out_all1  output  1  head result is all ones
- out_parity  output  1  XOR-reduction of head result
- txn_count  output  CNT_W  number of completed output handshakes, mod 2^CNT_W

## Operation
- The input handshake fires when in_valid && in_ready. The output handshake fires when out_valid && out_ready.
- On an input handshake, the block computes r and pushes {r, zero, all1, parity} into the buffer:
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 XOR: a^b
  - 011 NAND: ~(a&b)
  - 100 NOR: ~(a|b)
  - 101 XNOR: ~(a^b)
  - 110 NOT: ~a (b ignored)
  - 111 PASS: a (b ignored)
- Flags are computed from r at push time and stored with it. They are never recomputed from out_data.
- The buffer is a 2-entry FIFO with occupancy 0..2 and strict in-order delivery.
- out_data and the flags always show the head entry. They hold stable while out_valid && !out_ready.
- in_ready = (occupancy < 2). It is a registered/state-derived signal with no combinational path from out_ready or in_valid.
- out_valid = (occupancy > 0).
- Occupancy update per cycle: push only → +1; pop only → −1; push and pop together → unchanged (possible only at occupancy 1). At occupancy 2, no push is accepted even if a pop occurs that cycle.
- txn_count increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0. It has no saturation and no clear other than reset.
- Inputs are ignored when the handshake does not fire, including in_op values, X-free or not.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - occupancy 0
  - in_ready 1
  - out_valid 0
  - out_data 0
  - out_zero 1
  - out_all1 0
  - out_parity 0
  - txn_count 0
- Reset asserted mid-operation discards all buffered results immediately and takes effect without a clock edge.
- Latency: a result accepted at edge N is visible with out_valid=1 after edge N (1 cycle) when the buffer was empty.
- Throughput: 1 result/cycle sustained while out_ready stays high.
- With out_ready low, two operand sets are accepted on consecutive cycles, and in_ready falls after the second accept edge.
- After the first pop from full, in_ready is 1 in the following cycle.
- An empty buffer with out_ready high produces no handshake, and txn_count does not change.

## Test plan
- Reset: drive rst_n=0 mid-stream with 2 entries buffered → outputs go to the reset values above immediately; txn_count=0; after release, the first accepted op is the first delivered.
- Op sweep, WIDTH=8, a=8'hA5, b=8'h3C, out_ready=1, ops 000..111 on consecutive cycles → out_data 24, BD, 99, DB, 42, 66, 5A, A5 in order, each 1 cycle after accept. Flags: zero=0 and all1=0 on all; parity=0 for 24, BD, 99, DB, 42, 66, 5A, A5 (all even-weight). Separately, AND of 8'h0F/8'hF0 → zero=1, and PASS of 8'hFF → all1=1, parity=0; PASS of 8'h01 → parity=1.
- Backpressure: out_ready=0 with in_valid=1 for 4 cycles → exactly 2 accepted, in_ready=0 from cycle 2. Then out_ready=1 → both results delivered in order, in_ready returns to 1, txn_count=2.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1 and delivery order is preserved. Push while popping at occupancy 2 → input not accepted.
- Counter wrap, CNT_W=4 → 17 output handshakes give txn_count 0..15 then 1.
- Random valid/ready traffic against a reference queue model, 10k cycles → no loss, duplication or reordering; outputs stable while stalled.
